// File: rtl/cla_seq_adder.sv
// Sequential adder: consumes two operand bits per cycle through a 2-bit carry-lookahead slice.
// Define CLA_SEQ_ADDER_OVF_EN to add the signed-overflow output ovf.
module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [1:0]       p_s, g_s, slice_sum_s;
    logic             c1_s, c2_s;
    logic [WIDTH+1:0] sum_ext_s;

    // 2-bit carry-lookahead slice on the low operand bits
    always_comb begin
        p_s         = a_q[1:0] ^ b_q[1:0];
        g_s         = a_q[1:0] & b_q[1:0];
        c1_s        = g_s[0] | (p_s[0] & carry_q);
        c2_s        = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & carry_q);
        slice_sum_s = {p_s[1] ^ c1_s, p_s[0] ^ carry_q};
        // new slice bits enter at the MSB end; the first slice ends up at bits 1:0
        sum_ext_s   = {slice_sum_s, sum_q} >> 2;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = sum_ext_s[WIDTH-1:0];
                a_d     = a_q >> 2;
                b_d     = b_q >> 2;
                carry_d = c2_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_SLICE) begin
                    state_d = DONE;
                    cout_d  = c2_s;
                    ovf_d   = c1_s ^ c2_s;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_SEQ_ADDER_OVF_EN
    assign ovf       = ovf_q;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed testbench for cla_seq_adder (WIDTH=16) with a bench-side arithmetic model.
module tb_cla_seq_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_SEQ_ADDER_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef CLA_SEQ_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: result from plain arithmetic, timing from handshake rules
    int           m_phase;   // 0 idle, 1 running, 2 result offered
    int           m_left;
    logic [W-1:0] m_a, m_b, m_sum;
    logic         m_cin, m_cout, m_ovf, m_known;
    logic [W:0]   m_full;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_left <= 0;
            m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; m_known <= 1'b1;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_a <= a; m_b <= b; m_cin <= cin;
                m_left <= W / 2; m_phase <= 1; m_known <= 1'b0;
            end
        end else if (m_phase == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_full = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
                m_sum  <= m_full[W-1:0];
                m_cout <= m_full[W];
                m_ovf  <= (m_a[W-1] == m_b[W-1]) && (m_full[W-1] != m_a[W-1]);
                m_known <= 1'b1;
                m_phase <= 2;
            end
        end else begin
            if (out_ready) m_phase <= 0;
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
            if (m_known) begin
                chk("sum", {16'd0, sum}, {16'd0, m_sum});
                chk("cout", {31'd0, cout}, {31'd0, m_cout});
`ifdef CLA_SEQ_ADDER_OVF_EN
                chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
            end
        end
    end

    // Issue one operation; optionally glitch inputs during RUN and stall the consumer
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input int glitch_at, input int hold,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
            if (n == glitch_at) begin
                in_valid = 1'b1; a = 16'h0000; b = 16'h0000; cin = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("latency", n, 32'd8);
        chk("lit_sum", {16'd0, sum}, {16'd0, es});
        chk("lit_cout", {31'd0, cout}, {31'd0, ec});
`ifdef CLA_SEQ_ADDER_OVF_EN
        chk("lit_ovf", {31'd0, ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("note: unexpected X");
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, sum}, {16'd0, es});
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("released", {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         c;
        logic [W-1:0] s;
        logic         co, ov;
    } vec_t;

    vec_t vecs[6] = '{
        '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
        '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
        '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0}
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, 0, 0, vecs[i].s, vecs[i].co, vecs[i].ov);

        // stalled consumer with competing in_valid
        do_op(16'h0F0F, 16'h0101, 1'b0, 0, 5, 16'h1010, 1'b0, 1'b0);
        // in_valid pulse mid-RUN must not disturb the running operation
        do_op(16'h00FF, 16'h0001, 1'b0, 3, 0, 16'h0100, 1'b0, 1'b0);

        // reset during RUN cycle 4
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(16'h0002, 16'h0003, 1'b0, 0, 0, 16'h0005, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width (even, >= 2).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: operands and cin are valid.
REQ-005 SHALL have port in_ready, output, 1: block can accept operands.
REQ-006 SHALL have port a, input, WIDTH: operand A.
REQ-007 SHALL have port b, input, WIDTH: operand B.
REQ-008 SHALL have port cin, input, 1: carry-in.
REQ-009 SHALL have port out_valid, output, 1: sum and cout are valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port sum, output, WIDTH: a + b + cin, modulo 2^WIDTH.
REQ-012 SHALL have port cout, output, 1: carry out of bit WIDTH-1.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-015 SHALL accept operands in IDLE when in_valid & in_ready is high at a clock edge, and on that edge:
- latch a, b into operand shift registers;
- load cin into the carry register;
- clear the slice counter;
- enter RUN.
REQ-016 SHALL, on each RUN cycle, add the two low operand bits plus the carry register using a 2-bit carry-lookahead slice:
- p = a ^ b, g = a & b;
- c1 = g0 | p0 & c;
- c2 = g1 | p1 & g0 | p1 & p0 & c.
REQ-017 SHALL, on each RUN edge:
- shift the 2 slice sum bits into the sum register from the MSB end;
- shift the operands right by 2;
- load c2 into the carry register;
- increment the counter.
REQ-018 SHALL move from RUN to DONE on the edge where the counter equals WIDTH/2-1, so RUN lasts exactly WIDTH/2 cycles and out_valid rises WIDTH/2 cycles after the accept edge.
REQ-019 SHALL set cout to the carry register value at DONE entry (final c2).
REQ-020 SHALL hold sum and cout stable in DONE until out_valid & out_ready.
REQ-021 SHALL return from DONE to IDLE on the edge where out_valid & out_ready is high; sum and cout keep their last values in IDLE.
REQ-022 SHALL ignore in_valid, a, b and cin while in RUN or DONE; no queuing and no corruption of the running operation.
REQ-023 SHALL ignore out_ready outside DONE.
REQ-024 SHALL not accept new operands on the same edge that releases a result; minimum op spacing is WIDTH/2 + 2 cycles.
REQ-025 SHALL produce correct wrap-around: all-ones + 0 with cin = 1 gives sum 0 and cout 1.

Reset
REQ-026 SHALL, on rst = 1, immediately and asynchronously:
- enter IDLE;
- clear the counter, carry register, operand registers, sum and cout (and ovf, if present);
- drive in_ready = 1 and out_valid = 0.
REQ-027 SHALL abort any operation in progress on mid-operation reset, producing no out_valid for it.
REQ-028 SHALL be able to accept operands on the first clock edge after rst deasserts.

Configuration
REQ-029 SHALL, when macro CLA_SEQ_ADDER_OVF_EN is defined, add output port ovf (1 bit): signed overflow = c1 ^ c2 of the final slice. ovf is captured at DONE entry, held stable with sum, and reset to 0.
REQ-030 SHALL, when CLA_SEQ_ADDER_OVF_EN is undefined, omit the ovf port and its logic entirely, with all other behaviour identical.

Verification (WIDTH=16)
REQ-031 SHALL cover: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, out_valid high 8 cycles after accept.
REQ-032 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; with the macro defined, ovf=0.
REQ-033 SHALL cover, with the macro defined: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-034 SHALL cover: out_ready held low 5 cycles in DONE -> out_valid and sum held stable, in_ready stays 0, and a new in_valid is ignored until the release edge.
REQ-035 SHALL cover: in_valid pulsed with a=0x0000 at RUN cycle 3 of a 0x00FF+0x0001 op -> result is still 0x0100.
REQ-036 SHALL cover: rst asserted in RUN cycle 4 -> same-cycle IDLE, out_valid=0, sum=0; the next op 0x0002+0x0003 -> sum=0x0005.
